audio_cmd_ctrl: RTL
===================

// Module: audio_cmd_ctrl
// PURPOSE
//  Multi-track successor to the single-song audio controller. Decodes byte commands from uart_rx
//  (Bluetooth link) and drives the music sequencer: track select, restart, enable.
//  Adds stop/finish vs. cut modes, looping, a 1-deep next-track queue, PWM volume on the tone
//  output and a status LED. Sits between uart_rx and music, fully synchronous to i_clk.
// PARAMETERS
//  TRACK_W         2  track index width; NUM_TRACKS = 2**TRACK_W
//  VOL_W           4  volume width; PWM carrier period = 2**VOL_W clocks
//  DEFAULT_FINISH  1  reset play mode: 1 = let track finish, 0 = cut immediately
//  LED_ACTIVE_LOW  1  polarity of o_led
// PORTS
//  i_clk          in   1        system clock
//  i_rst          in   1        synchronous reset, active-high
//  i_rx_data      in   8        received command byte, valid with i_rx_valid
//  i_rx_valid     in   1        1-cycle strobe from uart_rx
//  i_track_done   in   1        sequencer done level (high = finished/idle)
//  i_pulse        in   1        raw tone from sequencer
//  o_play_en      out  1        sequencer enable
//  o_track_sel    out  TRACK_W  track index to sequencer
//  o_restart      out  1        1-cycle pulse: sequencer restarts at o_track_sel
//  o_pulse        out  1        volume-gated tone to speaker
//  o_led          out  1        lit while state != IDLE
//  o_busy         out  1        high in PLAY or DRAIN
//  o_cmd_err      out  1        1-cycle pulse on malformed command
// BEHAVIOUR
//  Reset: state IDLE; o_play_en=0, o_track_sel=0, o_restart=0, o_pulse=0, o_busy=0, o_cmd_err=0.
//   o_led is unlit. mode=DEFAULT_FINISH, loop=0, vol=all ones. Pending queue and done flag clear.
//  Reset mid-playback takes effect on the next edge and overrides any same-cycle command.
//  Opcode = i_rx_data[7:6], arg = [5:0]. Response is registered: strobe at edge N -> outputs at N+1.
//   00 STOP: arg must be 0.
//   01 PLAY: arg = track; arg bits above TRACK_W must be 0.
//   10 MODE: arg[0] = finish, arg[1] = loop, arg[5:2] must be 0.
//   11 VOL:  arg[VOL_W-1:0] = volume; bits above VOL_W must be 0.
//  Malformed command: o_cmd_err pulses and the command is otherwise ignored; no state change.
//  done_flag: set on a rising edge of i_track_done. Cleared when consumed or when o_restart fires.
//   Edges in the o_restart cycle and the cycle after are ignored.
//  FSM:
//   IDLE  PLAY n -> o_track_sel=n, o_restart, o_play_en=1 -> PLAY. STOP is a no-op.
//   PLAY  PLAY n, finish=1 -> pending=n (a later PLAY overwrites it).
//         PLAY n, finish=0 -> switch immediately with o_restart.
//         STOP, finish=1 -> DRAIN; finish=0 -> IDLE with o_play_en=0 and pending cleared.
//         done_flag consumed, in priority order: pending -> play it with o_restart, pending cleared;
//         else loop -> restart same track; else -> IDLE, o_play_en=0.
//   DRAIN PLAY n -> pending=n. STOP is a no-op.
//         done_flag -> if pending play it (PLAY state), else IDLE.
//  MODE and VOL are accepted in every state; they never change state or o_restart.
//  Simultaneous rx command and done edge: the command is processed first; done_flag stays set and
//   is consumed next cycle against the new state. A PLAY that issued o_restart clears it instead.
//  Volume: free-running VOL_W-bit counter c.
//   o_pulse = i_pulse & (c < vol) & o_play_en; vol=all ones forces o_pulse = i_pulse & o_play_en.
//   vol=0 mutes. o_pulse is registered (1-cycle latency).
//  o_led = LED_ACTIVE_LOW ? ~busy : busy.
// STRUCTURE
//  audio_defs.vh: opcode localparams (OP_STOP/OP_PLAY/OP_MODE/OP_VOL) and state encodings
//   S_IDLE/S_PLAY/S_DRAIN, shared with the future bench and uart command sender.
//  Sub-module audio_pwm_gain (counter + gate + output register); FSM and decode stay here.
// TESTING
//  T1 reset, then rx 0x42 -> next cycle o_track_sel=2, o_restart=1 for 1 cycle, o_play_en=1, o_led lit.
//  T2 finish mode: playing track 1, rx 0x00 -> DRAIN, o_play_en stays 1.
//     Raise i_track_done -> IDLE, o_play_en=0, o_led unlit.
//  T3 finish mode: playing 0, rx 0x43 then 0x41 -> pending=1; on done edge o_track_sel=1 with o_restart.
//  T4 cut mode (rx 0x80): playing 0, rx 0x43 -> next cycle o_track_sel=3, o_restart, no done wait.
//     rx 0x00 -> IDLE immediately.
//  T5 loop (rx 0x83) + done edge -> same track restarts. Done edge in the same cycle as rx 0x00
//     (finish) -> DRAIN, then IDLE next cycle.
//  T6 rx 0xC4 with i_pulse=1 -> o_pulse high 4 of 16 cycles. rx 0xC0 -> o_pulse=0.
//     rx 0x7F (TRACK_W=2) -> o_cmd_err pulse, state unchanged. i_rst mid-PLAY -> all outputs at reset values.

Source files
------------

// File: rtl/audio_cmd_ctrl_pkg.sv
// Shared opcode and state encodings for the audio command controller,
// plus the command byte layout used by the decoder.
package audio_cmd_ctrl_pkg;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_PLAY = 2'b01;
  localparam logic [1:0] OP_MODE = 2'b10;
  localparam logic [1:0] OP_VOL  = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_PLAY  = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b10;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] arg;
  } cmd_t;

  // True when no argument bit at or above position w is set.
  function automatic logic arg_fits(input logic [5:0] arg, input int w);
    return (arg >> w) == 6'd0;
  endfunction

endpackage

// File: rtl/audio_cmd_ctrl_pwm_gain.sv
// Volume gate for the sequencer tone: a free-running carrier counter compared
// against the volume, with a registered output.
module audio_pwm_gain #(
  parameter int VOL_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pulse,
  input  logic             i_en,
  input  logic [VOL_W-1:0] i_vol,
  output logic             o_pulse
);

  logic [VOL_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             gate;

  // Full-scale volume passes the tone untouched instead of dropping one slot.
  assign gate    = (&i_vol) | (cnt_q < i_vol);
  assign cnt_d   = cnt_q + 1'b1;
  assign pulse_d = i_pulse & i_en & gate;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/audio_cmd_ctrl.sv
// Byte-command decoder and playback FSM sitting between uart_rx and the music
// sequencer: track select/restart/enable, finish vs. cut, looping, 1-deep queue.
module audio_cmd_ctrl
  import audio_cmd_ctrl_pkg::*;
#(
  parameter int TRACK_W        = 2,
  parameter int VOL_W          = 4,
  parameter bit DEFAULT_FINISH = 1'b1,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_track_done,
  input  logic               i_pulse,
  output logic               o_play_en,
  output logic [TRACK_W-1:0] o_track_sel,
  output logic               o_restart,
  output logic               o_pulse,
  output logic               o_led,
  output logic               o_busy,
  output logic               o_cmd_err
);

  cmd_t               cmd;
  logic               cmd_ok;
  logic [TRACK_W-1:0] arg_trk;

  logic [1:0]         state_q, state_d;
  logic               finish_q, finish_d;
  logic               loop_q, loop_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic               pend_vld_q, pend_vld_d;
  logic [TRACK_W-1:0] pend_trk_q, pend_trk_d;
  logic               done_flag_q, done_flag_d;
  logic               done_prev_q;
  logic [TRACK_W-1:0] track_q, track_d;
  logic               play_en_q, play_en_d;
  logic               restart_q, restart_d;
  logic               restart_dly_q;
  logic               err_q, err_d;
  logic               done_rise, consume, busy;

  assign cmd     = cmd_t'(i_rx_data);
  assign arg_trk = cmd.arg[TRACK_W-1:0];

  always_comb begin
    cmd_ok = 1'b0;
    case (cmd.op)
      OP_STOP: cmd_ok = (cmd.arg == 6'd0);
      OP_PLAY: cmd_ok = arg_fits(cmd.arg, TRACK_W);
      OP_MODE: cmd_ok = arg_fits(cmd.arg, 2);
      default: cmd_ok = arg_fits(cmd.arg, VOL_W);
    endcase
  end

  // Done edges right after a restart belong to the track being left behind.
  assign done_rise = i_track_done & ~done_prev_q & ~restart_q & ~restart_dly_q;

  always_comb begin
    state_d    = state_q;
    finish_d   = finish_q;
    loop_d     = loop_q;
    vol_d      = vol_q;
    pend_vld_d = pend_vld_q;
    pend_trk_d = pend_trk_q;
    track_d    = track_q;
    play_en_d  = play_en_q;
    restart_d  = 1'b0;
    err_d      = 1'b0;
    consume    = 1'b0;

    if (i_rx_valid) begin
      if (!cmd_ok) begin
        err_d = 1'b1;
      end else begin
        case (cmd.op)
          OP_PLAY: begin
            if (state_q == S_IDLE) begin
              track_d   = arg_trk;
              restart_d = 1'b1;
              play_en_d = 1'b1;
              state_d   = S_PLAY;
            end else if (state_q == S_PLAY && !finish_q) begin
              track_d   = arg_trk;
              restart_d = 1'b1;
            end else begin
              pend_vld_d = 1'b1;
              pend_trk_d = arg_trk;
            end
          end
          OP_STOP: begin
            if (state_q == S_PLAY) begin
              if (finish_q) begin
                state_d = S_DRAIN;
              end else begin
                state_d    = S_IDLE;
                play_en_d  = 1'b0;
                pend_vld_d = 1'b0;
              end
            end
          end
          OP_MODE: begin
            finish_d = cmd.arg[0];
            loop_d   = cmd.arg[1];
          end
          default: vol_d = cmd.arg[VOL_W-1:0];
        endcase
      end
    end else if (done_flag_q && state_q != S_IDLE) begin
      consume = 1'b1;
      if (pend_vld_q) begin
        track_d    = pend_trk_q;
        restart_d  = 1'b1;
        pend_vld_d = 1'b0;
        state_d    = S_PLAY;
      end else if (state_q == S_PLAY && loop_q) begin
        restart_d = 1'b1;
      end else begin
        state_d   = S_IDLE;
        play_en_d = 1'b0;
      end
    end

    done_flag_d = done_flag_q;
    if (consume)   done_flag_d = 1'b0;
    if (done_rise) done_flag_d = 1'b1;
    if (restart_d) done_flag_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      finish_q      <= DEFAULT_FINISH;
      loop_q        <= 1'b0;
      vol_q         <= '1;
      pend_vld_q    <= 1'b0;
      done_flag_q   <= 1'b0;
      done_prev_q   <= i_track_done;
      track_q       <= '0;
      play_en_q     <= 1'b0;
      restart_q     <= 1'b0;
      restart_dly_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      finish_q      <= finish_d;
      loop_q        <= loop_d;
      vol_q         <= vol_d;
      pend_vld_q    <= pend_vld_d;
      done_flag_q   <= done_flag_d;
      done_prev_q   <= i_track_done;
      track_q       <= track_d;
      play_en_q     <= play_en_d;
      restart_q     <= restart_d;
      restart_dly_q <= restart_q;
      err_q         <= err_d;
    end
  end

  // Queued track is only meaningful while pend_vld_q is set.
  always_ff @(posedge i_clk) begin
    pend_trk_q <= pend_trk_d;
  end

  audio_pwm_gain #(.VOL_W(VOL_W)) u_pwm (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_pulse (i_pulse),
    .i_en    (play_en_q),
    .i_vol   (vol_q),
    .o_pulse (o_pulse)
  );

  assign busy        = (state_q != S_IDLE);
  assign o_busy      = busy;
  assign o_led       = LED_ACTIVE_LOW ? ~busy : busy;
  assign o_play_en   = play_en_q;
  assign o_track_sel = track_q;
  assign o_restart   = restart_q;
  assign o_cmd_err   = err_q;

endmodule
